// File: rtl/capsense_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// capsense_pkg : shared FSM encoding and sizing helpers for capsense_scan
// Revision 1.0
// ---------------------------------------------------------------------------
package capsense_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAL_DISCH = 3'd1,
    DISCH     = 3'd2,
    CHARGE    = 3'd3,
    EVAL      = 3'd4
  } state_t;

  // Bits needed for a counter spanning 0..n-1 (never less than one bit).
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [63:0] all_ones(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/capsense_scan_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// capsense_scan_debounce : per-channel agreement counter with press/release pulses
// Revision 1.0
// ---------------------------------------------------------------------------
module capsense_scan_debounce
  import capsense_pkg::*;
#(
  parameter int DEB = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic update,
  input  logic raw_touch,
  output logic button,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int DEB_W = width_of(DEB + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB - 1);

  logic [DEB_W-1:0] agree;

  always_ff @(posedge clk) begin
    if (rst) begin
      agree         <= '0;
      button        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (update) begin
        if (raw_touch == button) begin
          agree <= '0;
        end else if (agree == DEB_LAST) begin
          // DEB-th consecutive disagreement: flip and announce the edge
          agree         <= '0;
          button        <= ~button;
          press_pulse   <= raw_touch;
          release_pulse <= ~raw_touch;
        end else begin
          agree <= agree + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/capsense_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// capsense_scan : multi-channel capacitive-touch scanner with calibration and debounce
// Optional baseline drift tracking is enabled by defining CAPSENSE_TRACK_EN. Revision 1.0
// ---------------------------------------------------------------------------
module capsense_scan
  import capsense_pkg::*;
#(
  parameter int N           = 4,
  parameter int CNT_W       = 8,
  parameter int SAMP_DIV    = 16,
  parameter int POLL_W      = 12,
  parameter int DISCH_TICKS = 4,
  parameter int THRESH      = 8,
  parameter int DEB         = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N-1:0]       capsense_i,
  output logic               capsense_oe,
  output logic [N-1:0]       buttons_o,
  output logic [N-1:0]       press_o,
  output logic [N-1:0]       release_o,
  output logic               scan_done_o,
  output logic               cal_done_o,
  output logic [N*CNT_W-1:0] count_o
);

  localparam int DIV_W   = width_of(SAMP_DIV);
  localparam int DISCH_W = width_of(DISCH_TICKS);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SAMP_DIV - 1);
  localparam logic [DISCH_W-1:0] DISCH_LAST = DISCH_W'(DISCH_TICKS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(all_ones(CNT_W));
  localparam logic [CNT_W:0]     THR        = (CNT_W + 1)'(THRESH);

  state_t             state;
  state_t             state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [POLL_W-1:0]  poll_cnt;
  logic [DISCH_W-1:0] disch_cnt;
  logic               tick;
  logic               scan_start;
  logic               disch_state;
  logic               all_done;
  logic               deb_update;
  logic [CNT_W-1:0]   cnt  [N];
  logic [CNT_W-1:0]   base [N];
  logic [N-1:0]       stopped;
  logic [N-1:0]       raw_touch;

  assign tick        = (div_cnt == '0);
  assign scan_start  = tick && (poll_cnt == '0);
  assign disch_state = (state == DISCH) || (state == CAL_DISCH);
  assign deb_update  = (state == EVAL) && cal_done_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt  <= '0;
      poll_cnt <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (tick) poll_cnt <= poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disch_cnt <= '0;
    end else if (disch_state) begin
      if (tick) disch_cnt <= (disch_cnt == DISCH_LAST) ? '0 : disch_cnt + 1'b1;
    end else begin
      disch_cnt <= '0;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= CAL_DISCH;
    else       state <= state_next;
  end

  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!stopped[i] && (cnt[i] != CNT_MAX)) all_done = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:            if (scan_start) state_next = DISCH;
      CAL_DISCH,
      DISCH:           if (tick && (disch_cnt == DISCH_LAST)) state_next = CHARGE;
      CHARGE:          if (all_done) state_next = EVAL;
      EVAL:            state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    capsense_oe = 1'b1;
    scan_done_o = 1'b0;
    case (state)
      CHARGE:  capsense_oe = 1'b0;
      EVAL:    scan_done_o = 1'b1;
      default: ;
    endcase
  end

  // Charge-time counters; a channel freezes once its pad reads high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stopped <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (state == EVAL) begin
      stopped <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if ((state == CHARGE) && tick) begin
      for (int i = 0; i < N; i++) begin
        if (!stopped[i]) begin
          if (capsense_i[i])          stopped[i] <= 1'b1;
          else if (cnt[i] != CNT_MAX) cnt[i]     <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Extra MSB keeps baseline+THRESH from wrapping into a false touch
  always_comb begin
    raw_touch = '0;
    for (int i = 0; i < N; i++) begin
      raw_touch[i] = (cnt[i] == CNT_MAX) || ({1'b0, cnt[i]} >= ({1'b0, base[i]} + THR));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cal_done_o <= 1'b0;
      count_o    <= '0;
      for (int i = 0; i < N; i++) base[i] <= '0;
    end else if (state == EVAL) begin
      cal_done_o <= 1'b1;
      for (int i = 0; i < N; i++) begin
        count_o[i*CNT_W +: CNT_W] <= cnt[i];
        if (!cal_done_o) begin
          base[i] <= cnt[i];
        end
`ifdef CAPSENSE_TRACK_EN
        else if (!buttons_o[i] && !raw_touch[i]) begin
          if (cnt[i] > base[i])      base[i] <= base[i] + 1'b1;
          else if (cnt[i] < base[i]) base[i] <= base[i] - 1'b1;
        end
`endif
      end
    end
  end

  generate
    for (genvar g = 0; g < N; g++) begin : g_deb
      capsense_scan_debounce #(
        .DEB (DEB)
      ) u_deb (
        .clk           (clk_i),
        .rst           (rst_i),
        .update        (deb_update),
        .raw_touch     (raw_touch[g]),
        .button        (buttons_o[g]),
        .press_pulse   (press_o[g]),
        .release_pulse (release_o[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_capsense_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_capsense_scan : randomized scoreboard bench for capsense_scan with a pad RC model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_capsense_scan;

  localparam int N      = 4;
  localparam int CNT_W  = 8;
  localparam int S      = 2;
  localparam int THRESH = 8;
  localparam int DEB    = 3;
  localparam int CMAX   = 255;
  localparam int NEVER  = 1000;
  localparam int BUDGET = 3000;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       pad;
  logic               oe;
  logic [N-1:0]       buttons, press, rel;
  logic               scan_done, cal_done;
  logic [N*CNT_W-1:0] count;

  capsense_scan #(
    .N(N), .CNT_W(CNT_W), .SAMP_DIV(S), .POLL_W(6),
    .DISCH_TICKS(2), .THRESH(THRESH), .DEB(DEB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .capsense_i(pad), .capsense_oe(oe),
    .buttons_o(buttons), .press_o(press), .release_o(rel),
    .scan_done_o(scan_done), .cal_done_o(cal_done), .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*CNT_W-1:0] counts;
    logic               cal_before;
    logic [N-1:0]       btn_after;
    logic [N-1:0]       press;
    logic [N-1:0]       rel;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   c_cfg [N];   // pad rise time in sample ticks after release
  int   m_base[N];
  int   m_agree[N];
  bit   m_btn [N];
  bit   m_cal;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Pad model: each pad charges to 1 a fixed number of sample periods after oe drops
  initial begin
    int cyc;
    cyc = 0;
    pad = '0;
    forever begin
      @(posedge clk);
      #1;
      if (oe !== 1'b0) begin
        cyc = 0;
        pad = '0;
      end else begin
        for (int i = 0; i < N; i++) pad[i] = (c_cfg[i] < NEVER) && (cyc >= c_cfg[i] * S);
        cyc++;
      end
    end
  end

  task automatic model_reset();
    m_cal = 0;
    for (int i = 0; i < N; i++) begin
      m_base[i] = 0; m_agree[i] = 0; m_btn[i] = 0;
    end
  endtask

  // Reference: what one full scan with the current c_cfg should report
  task automatic predict(output exp_t e);
    int cnt;
    bit raw;
    e = '0;
    e.cal_before = m_cal;
    for (int i = 0; i < N; i++) begin
      cnt = (c_cfg[i] > CMAX) ? CMAX : c_cfg[i];
      e.counts[i*CNT_W +: CNT_W] = cnt[CNT_W-1:0];
      if (!m_cal) begin
        m_base[i] = cnt;
      end else begin
        raw = (cnt == CMAX) || (cnt >= m_base[i] + THRESH);
`ifdef CAPSENSE_TRACK_EN
        if (!m_btn[i] && !raw) begin
          if (cnt > m_base[i]) m_base[i]++;
          else if (cnt < m_base[i]) m_base[i]--;
        end
`endif
        if (raw == m_btn[i]) begin
          m_agree[i] = 0;
        end else begin
          m_agree[i]++;
          if (m_agree[i] == DEB) begin
            m_agree[i] = 0;
            m_btn[i]   = raw;
            e.press[i] = raw;
            e.rel[i]   = !raw;
          end
        end
      end
      e.btn_after[i] = m_btn[i];
    end
    m_cal = 1;
  endtask

  task automatic do_scan(input int c0, input int c1, input int c2, input int c3);
    exp_t e;
    bit   seen;
    c_cfg[0] = c0; c_cfg[1] = c1; c_cfg[2] = c2; c_cfg[3] = c3;
    predict(e);
    sb.push_back(e);
    seen = 0;
    for (int k = 0; k < BUDGET && !seen; k++) begin
      @(negedge clk);
      if (scan_done === 1'b1) seen = 1;
    end
    if (!seen) begin
      check("scan_timeout", 64'd0, 64'd1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per completed scan
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scan_done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_scan_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("cal_done_in_eval", 64'(cal_done), 64'(e.cal_before));
          @(negedge clk);
          check("count_o", 64'(count), 64'(e.counts));
          check("cal_done_after", 64'(cal_done), 64'd1);
          check("buttons_o", 64'(buttons), 64'(e.btn_after));
          check("press_o", 64'(press), 64'(e.press));
          check("release_o", 64'(rel), 64'(e.rel));
          check("scan_done_width", 64'(scan_done), 64'd0);
          @(negedge clk);
          check("pulse_clear", 64'({press, rel}), 64'd0);
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_oe", 64'(oe), 64'd1);
    check("rst_outputs", 64'({buttons, press, rel, scan_done, cal_done, count}), 64'd0);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < N; i++) c_cfg[i] = 5;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    do_scan(5, 5, 5, 5);
    repeat (3) do_scan(5, 20, 5, 5);
    repeat (3) begin
      do_scan(5, 5, 5, 5);
      do_scan(5, 20, 5, 5);
    end
    repeat (3) do_scan(5, 5, 5, 5);
    repeat (3) do_scan(5, 5, 5, NEVER);
    repeat (3) do_scan(5, 5, 5, 5);
    repeat (3) do_scan(0, 13, 12, 5);
    repeat (12) do_scan($urandom_range(30), $urandom_range(30), $urandom_range(30), $urandom_range(30));

    // Reset in the middle of a charge phase
    c_cfg[0] = 40; c_cfg[1] = 40; c_cfg[2] = 40; c_cfg[3] = 40;
    ok = 0;
    for (int k = 0; k < BUDGET && !ok; k++) begin
      @(negedge clk);
      if (oe === 1'b0) ok = 1;
    end
    if (!ok) check("charge_timeout", 64'd0, 64'd1);
    repeat (5) @(negedge clk);
    sb.delete();
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    do_scan(5, 5, 5, 5);
    repeat (4) do_scan(9, 9, 9, 9);
    do_scan(13, 13, 13, 13);
    repeat (4) do_scan($urandom_range(25), $urandom_range(25), $urandom_range(25), $urandom_range(25));

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
